fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Front-end fetch stage that owns the architectural fetch PC and queries the branch predictor combinationally every cycle. It issues word-aligned instruction-memory requests and tracks in-flight requests in order. Returned instructions are buffered, together with their PC and prediction, in a fetch queue consumed by decode. Backend redirects (mispredict, exception) flush the queue and discard stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
FQ_DEPTH, 4, fetch-queue entries (power of 2, >=2)
MAX_OUT, 2, maximum in-flight imem requests (power of 2, >=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
pred_pc  out  32  current fetch PC, to predictor
pred_valid  in  1  predictor BTB hit for pred_pc
pred_taken  in  1  predictor says taken
pred_target  in  32  predicted target
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  request address (= pc)
imem_resp_valid  in  1  response beat; always accepted, in request order
imem_resp_data  in  32  instruction word
redirect_valid  in  1  backend redirect
redirect_pc  in  32  redirect target
fq_valid  out  1  fetch queue non-empty
fq_ready  in  1  decode pops head
fq_pc  out  32  head PC
fq_instr  out  32  head instruction
fq_pred_taken  out  1  head predicted taken (pred_valid & pred_taken at issue)
fq_pred_target  out  32  head predicted target (0 if not predicted taken)

Behaviour:
- Reset (sync, rst=1 at posedge): pc=RESET_PC; fq empty; in-flight count=0; drop count=0. Outputs: imem_req_valid=0, fq_valid=0; fq_* data don't-care while fq_valid=0.
- pred_pc = pc (combinational). pc[1:0] always 00; redirect_pc[1:0] ignored.
- Credit: can_issue = (inflight + drop + fq_count) < FQ_DEPTH and (inflight + drop) < MAX_OUT and !redirect_valid.
- imem_req_valid = can_issue; imem_req_addr = pc. It may drop without handshake only on redirect.
- On fire (valid & ready): push {pc, pred_valid&pred_taken, target} to the in-flight tracker FIFO (depth MAX_OUT); pc <= (pred_valid&pred_taken) ? pred_target : pc+4 (mod 2^32 wrap).
- On imem_resp_valid:
  - drop>0: drop--, data discarded.
  - Otherwise: pop the tracker and push {pc, data, pred} into the FQ.
  - Credit guarantees the FQ never overflows. A response with the tracker empty and drop=0 is a protocol error (assertion).
- FQ pop on fq_valid & fq_ready. Push and pop in the same cycle are allowed, including at full. Response-to-fq_valid latency = 1 cycle (registered queue). Pointers wrap mod FQ_DEPTH.
- Redirect (highest priority), in the cycle redirect_valid=1:
  - No request issued.
  - pc <= redirect_pc & ~3.
  - FQ flushed; any same-cycle pop is ignored.
  - drop <= drop + inflight, including any response arriving in this same cycle; that response is itself dropped and decrements the total.
  - Tracker cleared.
  - Fetch resumes the next cycle.
- Back-to-back redirects: the last one wins; drop accumulates correctly.
- Reset mid-operation clears everything; late responses after reset are not protected (memory is reset too).
- Throughput: one request and one response per cycle sustained when imem is 1-cycle and decode is always ready.

Test Plan:
- Reset, imem ready, 1-cycle responses, fq_ready=1, no BTB hits -> requests at 0x0,0x4,0x8,...; fq_pc sequence identical; fq_pred_taken=0; one instr/cycle.
- BTB hit with pred_pc=0x8, pred_taken=1, pred_target=0x100 -> requests 0x0,0x4,0x8,0x100,0x104; entry for 0x8 has fq_pred_taken=1, fq_pred_target=0x100.
- fq_ready=0, FQ_DEPTH=4 -> exactly 4 requests fire, then imem_req_valid=0; one pop -> exactly one new request.
- Two requests in flight (0x10,0x14), redirect_pc=0x203 -> both responses dropped; next request addr=0x200; fq_valid stays 0 until the 0x200 response.
- Redirect in the same cycle as a response and an fq pop -> FQ empty next cycle, that response discarded, drop count correct (subsequent 0x200 data delivered, not stale).
- imem_req_ready held 0 for 5 cycles -> imem_req_addr stable, pc unchanged, no tracker push; single fire when ready rises.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit boundary bundle: predictor query, imem request/response, backend redirect and
// the fetch-queue head presented to decode. master = fetch unit, slave = its environment.
interface fetch_unit_if;
    logic [31:0] pred_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        fq_valid;
    logic        fq_ready;
    logic [31:0] fq_pc;
    logic [31:0] fq_instr;
    logic        fq_pred_taken;
    logic [31:0] fq_pred_target;

    modport master (
        output pred_pc,
        input  pred_valid, pred_taken, pred_target,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc,
        output fq_valid, fq_pc, fq_instr, fq_pred_taken, fq_pred_target,
        input  fq_ready
    );

    modport slave (
        input  pred_pc,
        output pred_valid, pred_taken, pred_target,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc,
        input  fq_valid, fq_pc, fq_instr, fq_pred_taken, fq_pred_target,
        output fq_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Front-end fetch stage: owns the fetch PC, issues credit-limited imem requests, tracks them in
// order and buffers returned instructions with their PC and prediction for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 4,
    parameter int unsigned MAX_OUT  = 2
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int unsigned FQ_PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned TR_PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CNT_W = $clog2(FQ_DEPTH + MAX_OUT + 1) + 1;

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] tr_cnt_q, tr_cnt_d;
    logic [CNT_W-1:0] fq_cnt_q, fq_cnt_d;
    logic [TR_PW-1:0] tr_rd_q, tr_rd_d, tr_wr_q, tr_wr_d;
    logic [FQ_PW-1:0] fq_rd_q, fq_rd_d, fq_wr_q, fq_wr_d;

    logic [31:0] tr_pc_q     [MAX_OUT];
    logic        tr_taken_q  [MAX_OUT];
    logic [31:0] tr_target_q [MAX_OUT];

    logic [31:0] fq_pc_q     [FQ_DEPTH];
    logic [31:0] fq_instr_q  [FQ_DEPTH];
    logic        fq_taken_q  [FQ_DEPTH];
    logic [31:0] fq_target_q [FQ_DEPTH];

    logic pred_hit;
    logic can_issue;
    logic fire;
    logic resp_drop;
    logic resp_keep;
    logic fq_pop;

    function automatic logic [TR_PW-1:0] tr_inc(input logic [TR_PW-1:0] p);
        return (p == TR_PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [FQ_PW-1:0] fq_inc(input logic [FQ_PW-1:0] p);
        return (p == FQ_PW'(FQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pred_hit = bus.pred_valid & bus.pred_taken;

    // Drop credits still occupy imem slots and FQ space until their stale beats return.
    always_comb begin
        can_issue = !rst && !bus.redirect_valid
                    && ((tr_cnt_q + drop_q + fq_cnt_q) < CNT_W'(FQ_DEPTH))
                    && ((tr_cnt_q + drop_q) < CNT_W'(MAX_OUT));
        fire      = can_issue && bus.imem_req_ready;
        resp_drop = bus.imem_resp_valid && (drop_q != '0);
        resp_keep = bus.imem_resp_valid && (drop_q == '0) && !bus.redirect_valid;
        fq_pop    = (fq_cnt_q != '0) && bus.fq_ready && !bus.redirect_valid;
    end

    always_comb begin
        pc_d     = pc_q;
        drop_d   = drop_q;
        tr_cnt_d = tr_cnt_q;
        tr_rd_d  = tr_rd_q;
        tr_wr_d  = tr_wr_q;
        fq_cnt_d = fq_cnt_q;
        fq_rd_d  = fq_rd_q;
        fq_wr_d  = fq_wr_q;
        if (bus.redirect_valid) begin
            // Everything in flight becomes stale; a beat landing now is one of those.
            pc_d     = bus.redirect_pc & ~32'h3;
            drop_d   = drop_q + tr_cnt_q - CNT_W'(bus.imem_resp_valid);
            tr_cnt_d = '0;
            tr_rd_d  = '0;
            tr_wr_d  = '0;
            fq_cnt_d = '0;
            fq_rd_d  = '0;
            fq_wr_d  = '0;
        end else begin
            if (fire) begin
                pc_d    = pred_hit ? (bus.pred_target & ~32'h3) : pc_q + 32'd4;
                tr_wr_d = tr_inc(tr_wr_q);
            end
            if (resp_drop) begin
                drop_d = drop_q - 1'b1;
            end
            if (resp_keep) begin
                tr_rd_d = tr_inc(tr_rd_q);
                fq_wr_d = fq_inc(fq_wr_q);
            end
            if (fq_pop) begin
                fq_rd_d = fq_inc(fq_rd_q);
            end
            tr_cnt_d = tr_cnt_q + CNT_W'(fire) - CNT_W'(resp_keep);
            fq_cnt_d = fq_cnt_q + CNT_W'(resp_keep) - CNT_W'(fq_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            drop_q   <= '0;
            tr_cnt_q <= '0;
            tr_rd_q  <= '0;
            tr_wr_q  <= '0;
            fq_cnt_q <= '0;
            fq_rd_q  <= '0;
            fq_wr_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            drop_q   <= drop_d;
            tr_cnt_q <= tr_cnt_d;
            tr_rd_q  <= tr_rd_d;
            tr_wr_q  <= tr_wr_d;
            fq_cnt_q <= fq_cnt_d;
            fq_rd_q  <= fq_rd_d;
            fq_wr_q  <= fq_wr_d;
        end
    end

    // Payload storage needs no reset: occupancy counters qualify every read.
    always_ff @(posedge clk) begin
        if (fire) begin
            tr_pc_q[tr_wr_q]     <= pc_q;
            tr_taken_q[tr_wr_q]  <= pred_hit;
            tr_target_q[tr_wr_q] <= pred_hit ? bus.pred_target : 32'h0;
        end
        if (resp_keep && !rst) begin
            fq_pc_q[fq_wr_q]     <= tr_pc_q[tr_rd_q];
            fq_instr_q[fq_wr_q]  <= bus.imem_resp_data;
            fq_taken_q[fq_wr_q]  <= tr_taken_q[tr_rd_q];
            fq_target_q[fq_wr_q] <= tr_target_q[tr_rd_q];
        end
    end

    assign bus.pred_pc        = pc_q;
    assign bus.imem_req_valid = can_issue;
    assign bus.imem_req_addr  = pc_q;
    assign bus.fq_valid       = (fq_cnt_q != '0);
    assign bus.fq_pc          = fq_pc_q[fq_rd_q];
    assign bus.fq_instr       = fq_instr_q[fq_rd_q];
    assign bus.fq_pred_taken  = fq_taken_q[fq_rd_q];
    assign bus.fq_pred_target = fq_target_q[fq_rd_q];

    // A beat with nothing tracked and nothing to drop means the memory broke ordering.
    resp_has_owner: assert property (@(posedge clk) disable iff (rst)
        bus.imem_resp_valid |-> ((drop_q != '0) || (tr_cnt_q != '0)));
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written multi-cycle corners, and random
// traffic checked against a queue-based reference model of the fetch front end.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int FQ_DEPTH = 4;
    localparam int MAX_OUT  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bif();

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .FQ_DEPTH(FQ_DEPTH),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    typedef struct { logic [31:0] pc; logic taken; logic [31:0] tgt; } tr_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic taken; logic [31:0] tgt; } fq_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct {
        logic ready; logic fq_ready;
        logic req_valid; logic [31:0] req_addr;
        logic fq_valid; logic [31:0] fq_pc; logic fq_taken; logic [31:0] fq_tgt;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Environment knobs
    bit          f_rst = 1'b0;
    bit          f_redir = 1'b0;
    logic [31:0] f_redir_pc = '0;
    int          k_ready_mode = 0;  // 0 always, 1 random, 2 never
    int          k_fqr_mode = 0;
    int          k_redir_pct = 0;
    int          k_lat_min = 1, k_lat_max = 1;
    logic [31:0] btb_pc [4];
    logic [31:0] btb_tgt[4];
    int          btb_n = 0;

    mreq_t mem_q[$];
    int    last_due = 0;

    // Reference model
    logic [31:0] m_pc;
    int          m_drop;
    tr_t         m_tr[$];
    fq_t         m_fq[$];

    // Per-cycle samples
    logic        s_req_valid, s_fq_valid, s_fq_taken, s_fire;
    logic [31:0] s_req_addr, s_pred_pc, s_fq_pc, s_fq_instr, s_fq_tgt;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
    endfunction

    task automatic btb_lookup(input logic [31:0] pc, output bit hit, output logic [31:0] tgt);
        hit = 1'b0;
        tgt = '0;
        for (int i = 0; i < btb_n; i++) begin
            if (btb_pc[i] === pc) begin
                hit = 1'b1;
                tgt = btb_tgt[i];
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit pick(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ($urandom_range(0, 3) != 0);
        return 1'b0;
    endfunction

    task automatic cycle();
        bit          ready, fqr, redir, resp, hit, m_hit, e_req;
        logic [31:0] rpc, tgt, m_tgt, rnd;
        int          noise, due;
        fq_t         fe;
        tr_t         te;

        ready = pick(k_ready_mode);
        fqr   = pick(k_fqr_mode);
        redir = f_redir || (k_redir_pct != 0 && $urandom_range(0, 99) < k_redir_pct);
        rnd   = $urandom_range(0, 32'h3FF);
        rpc   = f_redir ? f_redir_pc : rnd;
        resp  = !f_rst && mem_q.size() > 0 && mem_q[0].due <= cyc;
        btb_lookup(bif.pred_pc, hit, tgt);
        noise = $urandom_range(0, 3);

        rst                 = f_rst;
        bif.imem_req_ready  = ready;
        bif.fq_ready        = fqr;
        bif.redirect_valid  = redir;
        bif.redirect_pc     = rpc;
        bif.imem_resp_valid = resp;
        bif.imem_resp_data  = resp ? instr_of(mem_q[0].addr) : $urandom;
        bif.pred_valid      = hit || noise == 1;
        bif.pred_taken      = hit || noise == 2;
        bif.pred_target     = hit ? tgt : $urandom;

        @(negedge clk);
        s_req_valid = bif.imem_req_valid;
        s_req_addr  = bif.imem_req_addr;
        s_pred_pc   = bif.pred_pc;
        s_fq_valid  = bif.fq_valid;
        s_fq_pc     = bif.fq_pc;
        s_fq_instr  = bif.fq_instr;
        s_fq_taken  = bif.fq_pred_taken;
        s_fq_tgt    = bif.fq_pred_target;
        s_fire      = s_req_valid && ready;

        e_req = 1'b0;
        if (!f_rst) begin
            e_req = (m_tr.size() + m_drop + m_fq.size() < FQ_DEPTH)
                    && (m_tr.size() + m_drop < MAX_OUT) && !redir;
            chk("m_req_valid", s_req_valid, e_req);
            chk("m_pred_pc", s_pred_pc, m_pc);
            if (e_req) chk("m_req_addr", s_req_addr, m_pc);
            chk("m_fq_valid", s_fq_valid, m_fq.size() > 0);
            if (m_fq.size() > 0) begin
                chk("m_fq_pc", s_fq_pc, m_fq[0].pc);
                chk("m_fq_instr", s_fq_instr, m_fq[0].instr);
                chk("m_fq_taken", s_fq_taken, m_fq[0].taken);
                chk("m_fq_target", s_fq_tgt, m_fq[0].tgt);
            end
        end

        // Memory: in-order responses, latency randomised but strictly increasing due times
        if (f_rst) begin
            mem_q.delete();
            last_due = 0;
        end else begin
            if (resp) void'(mem_q.pop_front());
            if (s_fire) begin
                due = cyc + $urandom_range(k_lat_min, k_lat_max);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{addr: s_req_addr, due: due});
            end
        end

        if (f_rst) begin
            m_pc   = RESET_PC;
            m_drop = 0;
            m_tr.delete();
            m_fq.delete();
        end else if (redir) begin
            m_drop = m_drop + m_tr.size() - (resp ? 1 : 0);
            m_tr.delete();
            m_fq.delete();
            m_pc = rpc & ~32'h3;
        end else begin
            if (fqr && m_fq.size() > 0) void'(m_fq.pop_front());
            if (resp) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else if (m_tr.size() > 0) begin
                    te = m_tr.pop_front();
                    fe = '{pc: te.pc, instr: instr_of(te.pc), taken: te.taken, tgt: te.tgt};
                    m_fq.push_back(fe);
                end
            end
            if (e_req && ready) begin
                btb_lookup(m_pc, m_hit, m_tgt);
                m_tr.push_back('{pc: m_pc, taken: m_hit, tgt: m_hit ? m_tgt : 32'h0});
                m_pc = m_hit ? m_tgt : m_pc + 32'd4;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        f_rst = 1'b1;
        f_redir = 1'b0;
        cycle();
        cycle();
        chk("rst_req_valid", s_req_valid, 1'b0);
        chk("rst_fq_valid", s_fq_valid, 1'b0);
        f_rst = 1'b0;
    endtask

    task automatic wait_first_fq(input string name, input logic [31:0] pc);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (s_fq_valid) begin
                seen = 1'b1;
                chk({name, "_pc"}, s_fq_pc, pc);
                chk({name, "_instr"}, s_fq_instr, instr_of(pc));
            end
        end
        chk({name, "_seen"}, seen, 1'b1);
    endtask

    vec_t vt[11];

    initial begin
        int          fires;
        bit          got;
        logic [31:0] first_addr;

        vt[0]  = '{1, 1, 1, 32'h000, 0, 32'h000, 0, 32'h000};
        vt[1]  = '{1, 1, 1, 32'h004, 0, 32'h000, 0, 32'h000};
        vt[2]  = '{1, 1, 1, 32'h008, 1, 32'h000, 0, 32'h000};
        vt[3]  = '{1, 1, 1, 32'h100, 1, 32'h004, 0, 32'h000};
        vt[4]  = '{1, 1, 1, 32'h104, 1, 32'h008, 1, 32'h100};
        vt[5]  = '{1, 1, 1, 32'h108, 1, 32'h100, 0, 32'h000};
        vt[6]  = '{1, 1, 1, 32'h10c, 1, 32'h104, 0, 32'h000};
        vt[7]  = '{0, 1, 1, 32'h110, 1, 32'h108, 0, 32'h000};
        vt[8]  = '{1, 1, 1, 32'h110, 1, 32'h10c, 0, 32'h000};
        vt[9]  = '{1, 1, 1, 32'h114, 0, 32'h000, 0, 32'h000};
        vt[10] = '{1, 1, 1, 32'h118, 1, 32'h110, 0, 32'h000};

        @(posedge clk);
        #1;

        // Directed table: sequential fetch, BTB hit at 0x8 -> 0x100, one imem stall
        btb_n = 1; btb_pc[0] = 32'h8; btb_tgt[0] = 32'h100;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            k_ready_mode = vt[i].ready ? 0 : 2;
            k_fqr_mode   = vt[i].fq_ready ? 0 : 2;
            cycle();
            chk($sformatf("vec%0d_req_valid", i), s_req_valid, vt[i].req_valid);
            if (vt[i].req_valid) chk($sformatf("vec%0d_req_addr", i), s_req_addr, vt[i].req_addr);
            chk($sformatf("vec%0d_fq_valid", i), s_fq_valid, vt[i].fq_valid);
            if (vt[i].fq_valid) begin
                chk($sformatf("vec%0d_fq_pc", i), s_fq_pc, vt[i].fq_pc);
                chk($sformatf("vec%0d_fq_taken", i), s_fq_taken, vt[i].fq_taken);
                chk($sformatf("vec%0d_fq_target", i), s_fq_tgt, vt[i].fq_tgt);
            end
        end
        btb_n = 0;
        k_ready_mode = 0;
        k_fqr_mode = 0;

        // Decode stalled: FQ credit allows exactly FQ_DEPTH fires, one pop frees one more
        do_reset();
        k_fqr_mode = 2;
        fires = 0;
        for (int i = 0; i < 10; i++) begin cycle(); fires += s_fire; end
        chk("stall_fires", fires, FQ_DEPTH);
        chk("stall_req_valid", s_req_valid, 1'b0);
        k_fqr_mode = 0;
        cycle();
        k_fqr_mode = 2;
        fires = 0;
        for (int i = 0; i < 6; i++) begin cycle(); fires += s_fire; end
        chk("stall_pop_fires", fires, 1);
        k_fqr_mode = 0;

        // Two in flight at 0x10/0x14, redirect to 0x203: both beats dropped, fetch from 0x200
        do_reset();
        k_lat_min = 3; k_lat_max = 3;
        f_redir = 1'b1; f_redir_pc = 32'h10; cycle(); f_redir = 1'b0;
        cycle();
        chk("inflight_addr0", s_req_addr, 32'h10);
        cycle();
        chk("inflight_addr1", s_req_addr, 32'h14);
        f_redir = 1'b1; f_redir_pc = 32'h203; cycle(); f_redir = 1'b0;
        chk("redir_no_req", s_req_valid, 1'b0);
        got = 1'b0;
        first_addr = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            chk("redir_fq_quiet", s_fq_valid, 1'b0);
            if (s_fire) begin got = 1'b1; first_addr = s_req_addr; end
        end
        chk("redir_first_addr", first_addr, 32'h200);
        wait_first_fq("redir_fq", 32'h200);
        k_lat_min = 1; k_lat_max = 1;

        // Redirect coinciding with a response and a decode pop
        do_reset();
        for (int i = 0; i < 4; i++) cycle();
        f_redir = 1'b1; f_redir_pc = 32'h200; cycle(); f_redir = 1'b0;
        chk("same_cyc_resp", bif.imem_resp_valid, 1'b1);
        cycle();
        chk("same_cyc_flush", s_fq_valid, 1'b0);
        wait_first_fq("same_cyc_fq", 32'h200);

        // imem not ready for 5 cycles: request held, PC frozen, then a single fire
        do_reset();
        k_ready_mode = 2;
        fires = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            fires += s_fire;
            chk("hold_req_valid", s_req_valid, 1'b1);
            chk("hold_req_addr", s_req_addr, RESET_PC);
            chk("hold_pred_pc", s_pred_pc, RESET_PC);
        end
        chk("hold_fires", fires, 0);
        k_ready_mode = 0;
        cycle();
        chk("hold_release_fire", s_fire, 1'b1);
        cycle();
        chk("hold_next_addr", s_req_addr, RESET_PC + 32'd4);

        // Random traffic against the reference model
        for (int i = 0; i < 4; i++) begin
            btb_pc[i]  = $urandom_range(0, 255) << 2;
            btb_tgt[i] = $urandom_range(0, 255) << 2;
        end
        btb_n = 4;
        do_reset();
        k_ready_mode = 1; k_fqr_mode = 1; k_redir_pct = 4; k_lat_min = 1; k_lat_max = 4;
        for (int i = 0; i < 3000; i++) cycle();
        do_reset();
        k_ready_mode = 0; k_fqr_mode = 0; k_redir_pct = 2; k_lat_min = 1; k_lat_max = 1;
        for (int i = 0; i < 1000; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
